// File: rtl/dma_io_peripheral.sv
// Peripheral-side endpoint of a single DMA request/acknowledge channel.
// Sources bytes onto DB from a local FIFO (DIR=0) or sinks DB into it (DIR=1).
module dma_io_peripheral #(
    parameter int DEPTH  = 4,
    parameter int THRESH = 1
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   DIR,
    output logic                   DREQ,
    input  logic                   DACK,
    input  logic                   IOR_N,
    input  logic                   IOW_N,
    input  logic                   EOP_N_IN,
    output logic                   EOP_N_OUT,
    input  logic [7:0]             DB_IN,
    output logic [7:0]             DB_OUT,
    output logic                   DB_OE,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    input  logic                   rd_ready,
    input  logic                   abort,
    output logic [$clog2(DEPTH):0] level,
    output logic                   done,
    output logic                   ovf_err,
    output logic                   unf_err,
    output logic [1:0]             fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, TERM = 2'd3} state_t;

    state_t         state, state_nxt;
    logic           dir_q;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  count, count_nxt;
    logic [7:0]     cap_q;
    logic           abort_pend, eop_seen, done_q, ovf_q, unf_q;
    logic           strobe_low, window, commit, terminated, full, empty;
    logic           loc_push, loc_pop, bus_push, bus_pop, push, pop;
    logic [7:0]     push_data;

    function automatic logic eligible(input logic d, input logic [LW-1:0] c);
        if (d) return (DEPTH - int'(c)) >= THRESH;
        return int'(c) >= THRESH;
    endfunction

    // Handshake: a strobe counts only while DACK=1; the bus cycle commits on the
    // first XFER cycle the strobe is seen inactive, even if DACK has already dropped.
    always_comb begin
        strobe_low = DACK && (dir_q ? !IOW_N : !IOR_N);
        window     = (state == XFER) || ((state == REQ) && strobe_low);
        commit     = (state == XFER) && !strobe_low;
        terminated = eop_seen || abort_pend || (DACK && !EOP_N_IN);
        full       = (count == LW'(DEPTH));
        empty      = (count == '0);
        loc_push   = wr_valid && !full && !dir_q;
        loc_pop    = rd_ready && !empty && dir_q;
        bus_push   = commit && dir_q && !full;
        bus_pop    = commit && !dir_q && !empty;
        push       = loc_push || bus_push;
        pop        = loc_pop || bus_pop;
        push_data  = dir_q ? cap_q : wr_data;
        count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Holding DACK after the block goes ineligible keeps it in REQ so the
    // controller can still force a strobe (exercises overflow/underrun).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (eligible(DIR, count)) state_nxt = REQ;
            REQ: begin
                if (strobe_low)                               state_nxt = XFER;
                else if (!DACK && !eligible(dir_q, count))    state_nxt = IDLE;
            end
            XFER: begin
                if (commit) begin
                    if (terminated)                               state_nxt = TERM;
                    else if (eligible(dir_q, count_nxt) || DACK)  state_nxt = REQ;
                    else                                          state_nxt = IDLE;
                end
            end
            TERM: if (!DACK) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DREQ      = ((state == REQ) || (state == XFER)) && eligible(dir_q, count);
        DB_OE     = !dir_q && window && strobe_low;
        DB_OUT    = DB_OE ? (empty ? 8'hFF : mem[rd_ptr]) : 8'h00;
        EOP_N_OUT = !(abort_pend && window);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dir_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cap_q      <= 8'h00;
            abort_pend <= 1'b0;
            eop_seen   <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (state == IDLE) dir_q <= DIR;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            if (dir_q && window && strobe_low) cap_q <= DB_IN;
            if (commit && abort_pend) abort_pend <= 1'b0;
            else if (abort)           abort_pend <= 1'b1;
            if (commit)                              eop_seen <= 1'b0;
            else if (window && DACK && !EOP_N_IN)    eop_seen <= 1'b1;
            done_q <= (state != TERM) && (state_nxt == TERM);
            if (commit && dir_q && full)   ovf_q <= 1'b1;
            if (commit && !dir_q && empty) unf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign level     = count;
    assign done      = done_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
    assign rd_data   = mem[rd_ptr];
    assign wr_ready  = !full && !dir_q;
    assign rd_valid  = !empty && dir_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral: source, sink, EOP, abort, coincident
// push/commit and asynchronous reset scenarios with hand-computed expectations.
module tb_dma_io_peripheral;
    logic       clk = 1'b0;
    logic       rst_n, dir, dreq, dack, ior_n, iow_n, eop_n_in, eop_n_out;
    logic [7:0] db_in, db_out, wr_data, rd_data;
    logic       db_oe, wr_valid, wr_ready, rd_valid, rd_ready, abort;
    logic [2:0] level;
    logic       done, ovf_err, unf_err;
    logic [1:0] fsm_state;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dma_io_peripheral #(.DEPTH(4), .THRESH(1)) dut (
        .CLK(clk), .RESET_N(rst_n), .DIR(dir), .DREQ(dreq), .DACK(dack),
        .IOR_N(ior_n), .IOW_N(iow_n), .EOP_N_IN(eop_n_in), .EOP_N_OUT(eop_n_out),
        .DB_IN(db_in), .DB_OUT(db_out), .DB_OE(db_oe),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .abort(abort), .level(level), .done(done), .ovf_err(ovf_err),
        .unf_err(unf_err), .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic d);
        rst_n = 1'b0; dir = d; dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
        eop_n_in = 1'b1; db_in = 8'h00; wr_valid = 1'b0; wr_data = 8'h00;
        rd_ready = 1'b0; abort = 1'b0;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        exp_q.push_back(d);
        step();
        wr_valid = 1'b0;
    endtask

    // One IOR_N low cycle, then the commit cycle; optional local push at commit.
    task automatic src_pulse(input string tag, input logic do_push, input logic [7:0] pd);
        logic [7:0] e;
        ior_n = 1'b0;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        check({tag, "_oe"}, db_oe, 1'b1);
        check({tag, "_db"}, db_out, e);
        step();
        ior_n = 1'b1;
        if (do_push) begin
            wr_valid = 1'b1; wr_data = pd;
            exp_q.push_back(pd);
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic snk_pulse(input logic [7:0] d);
        db_in = d; iow_n = 1'b0;
        step();
        iow_n = 1'b1; db_in = 8'h00;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset(1'b0);
        @(negedge clk);
        check("rst_dreq", dreq, 1'b0);
        check("rst_oe", db_oe, 1'b0);
        check("rst_db", db_out, 8'h00);
        check("rst_eop", eop_n_out, 1'b1);
        check("rst_level", level, 3'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", {ovf_err, unf_err}, 2'b00);
        check("rst_state", fsm_state, 2'd0);

        // Source: A5, 3C out in order, then a forced underrun pulse
        step();
        push(8'hA5);
        push(8'h3C);
        @(negedge clk);
        check("src_state_req", fsm_state, 2'd1);
        check("src_dreq_on", dreq, 1'b1);
        check("src_level2", level, 3'd2);
        step();
        dack = 1'b1;
        src_pulse("src1", 1'b0, 8'h00);
        check("src_level1", level, 3'd1);
        check("src_dreq_mid", dreq, 1'b1);
        src_pulse("src2", 1'b0, 8'h00);
        @(negedge clk);
        check("src_level0", level, 3'd0);
        check("src_dreq_off", dreq, 1'b0);
        src_pulse("unf", 1'b0, 8'h00);
        @(negedge clk);
        check("unf_err", unf_err, 1'b1);
        check("unf_level", level, 3'd0);
        check("unf_ovf", ovf_err, 1'b0);
        dack = 1'b0;
        step();

        // Sink: 01..04 in, forced 5th overflows
        do_reset(1'b1);
        step();
        @(negedge clk);
        check("snk_dreq_on", dreq, 1'b1);
        step();
        dack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            snk_pulse(8'(i));
            exp_q.push_back(8'(i));
            if (i == 3) check("snk_dreq3", dreq, 1'b1);
        end
        @(negedge clk);
        check("snk_level4", level, 3'd4);
        check("snk_dreq_off", dreq, 1'b0);
        check("snk_ovf_pre", ovf_err, 1'b0);
        snk_pulse(8'h05);
        @(negedge clk);
        check("snk_ovf", ovf_err, 1'b1);
        check("snk_level_ovf", level, 3'd4);
        dack = 1'b0;
        step();
        @(negedge clk);
        check("snk_rd_valid", rd_valid, 1'b1);
        check("snk_wr_ready", wr_ready, 1'b0);
        step();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("snk_rd%0d", i), rd_data, exp_q.pop_front());
            step();
        end
        rd_ready = 1'b0;
        @(negedge clk);
        check("snk_drained", level, 3'd0);
        check("snk_rd_empty", rd_valid, 1'b0);

        // EOP_N_IN during 2nd of 3 source transfers
        do_reset(1'b0);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        dack = 1'b1;
        src_pulse("eop1", 1'b0, 8'h00);
        ior_n = 1'b0; eop_n_in = 1'b0;
        @(negedge clk);
        check("eop2_db", db_out, exp_q.pop_front());
        step();
        ior_n = 1'b1; eop_n_in = 1'b1;
        step();
        @(negedge clk);
        check("eop_done", done, 1'b1);
        check("eop_dreq", dreq, 1'b0);
        check("eop_level", level, 3'd1);
        check("eop_state", fsm_state, 2'd3);
        step();
        @(negedge clk);
        check("eop_done_once", done, 1'b0);
        dack = 1'b0;
        step();
        @(negedge clk);
        check("eop_idle", fsm_state, 2'd0);
        check("eop_head", rd_data, exp_q[0]);

        // abort: EOP_N_OUT low only across the next transfer
        do_reset(1'b0);
        push(8'h77);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abt_eop_pre", eop_n_out, 1'b1);
        step();
        dack = 1'b1; ior_n = 1'b0;
        @(negedge clk);
        check("abt_eop_strobe", eop_n_out, 1'b0);
        check("abt_db", db_out, exp_q.pop_front());
        step();
        ior_n = 1'b1;
        @(negedge clk);
        check("abt_eop_commit", eop_n_out, 1'b0);
        step();
        @(negedge clk);
        check("abt_eop_post", eop_n_out, 1'b1);
        check("abt_done", done, 1'b1);
        dack = 1'b0;
        step();

        // Local push coincident with source commit at level 2
        do_reset(1'b0);
        push(8'h10);
        push(8'h20);
        dack = 1'b1;
        src_pulse("co1", 1'b1, 8'h30);
        @(negedge clk);
        check("co_level", level, 3'd2);
        src_pulse("co2", 1'b0, 8'h00);
        src_pulse("co3", 1'b0, 8'h00);
        @(negedge clk);
        check("co_level0", level, 3'd0);
        dack = 1'b0;
        step();

        // Asynchronous reset in the middle of XFER
        do_reset(1'b0);
        push(8'h44);
        step();
        dack = 1'b1; ior_n = 1'b0;
        step();
        @(negedge clk);
        check("mid_state_xfer", fsm_state, 2'd2);
        check("mid_oe", db_oe, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dreq", dreq, 1'b0);
        check("mid_rst_oe", db_oe, 1'b0);
        check("mid_rst_level", level, 3'd0);
        check("mid_rst_state", fsm_state, 2'd0);
        ior_n = 1'b1; dack = 1'b0; dir = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_wr_ready", wr_ready, 1'b1);
        step();
        @(negedge clk);
        check("mid_dir_sink", wr_ready, 1'b0);
        check("mid_req", fsm_state, 2'd1);
        check("mid_dreq", dreq, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
